// File: rtl/meter_pkg.sv
// Shared types and constants for the parking-meter command scheduler.
// Optional build macro used by the slice: BUTTON_REPEAT_EN (hold-to-repeat credit buttons).
package meter_pkg;

    localparam int CMD_W = 14;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_LOAD = 2'd1,
        OP_ADD  = 2'd2,
        OP_DEC  = 2'd3
    } cmd_op_e;

    localparam int SRC_SW10   = 0;
    localparam int SRC_SW205  = 1;
    localparam int SRC_BTN_U  = 2;
    localparam int SRC_BTN_L  = 3;
    localparam int SRC_BTN_R  = 4;
    localparam int SRC_BTN_D  = 5;
    localparam int NUM_SRC    = 6;

    localparam logic [CMD_W-1:0] AMT_10  = 14'd10;
    localparam logic [CMD_W-1:0] AMT_180 = 14'd180;
    localparam logic [CMD_W-1:0] AMT_200 = 14'd200;
    localparam logic [CMD_W-1:0] AMT_550 = 14'd550;
    localparam logic [CMD_W-1:0] AMT_205 = 14'd205;
    localparam logic [CMD_W-1:0] AMT_MAX = 14'd9999;
    localparam logic [CMD_W-1:0] AMT_DEC = 14'd1;

    function automatic logic [CMD_W-1:0] srcAmount(input int src);
        case (src)
            SRC_SW10:  return AMT_10;
            SRC_SW205: return AMT_205;
            SRC_BTN_U: return AMT_10;
            SRC_BTN_L: return AMT_180;
            SRC_BTN_R: return AMT_200;
            SRC_BTN_D: return AMT_550;
            default:   return '0;
        endcase
    endfunction

endpackage

// File: rtl/meter_debounce.sv
// Two-flop synchroniser, consecutive-sample debouncer and rising-edge pulse for one raw input.
// With BUTTON_REPEAT_EN defined, a repeat-capable instance also pulses every REPEAT_CYCLES while held.
module meter_debounce
    import meter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
`ifdef BUTTON_REPEAT_EN
    , parameter int REPEAT_CYCLES = 50_000_000,
    parameter bit CAN_REPEAT = 1'b0
`endif
)(
    input  logic CLK,
    input  logic RESET_N,
    input  logic i_raw,
    output logic o_rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differs;
    logic             w_settled;
    logic             w_edge;

    assign w_differs = (r_sync2 != r_level);
    assign w_settled = w_differs && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign w_edge    = w_settled && r_sync2;

    // Any sample matching the current level restarts the stability count.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (!w_differs || w_settled) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_settled) begin
                r_level <= r_sync2;
            end
        end
    end

`ifdef BUTTON_REPEAT_EN
    logic w_repeat;

    if (CAN_REPEAT) begin : g_repeat
        localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
        logic [REP_W-1:0] r_rep_cnt;

        assign w_repeat = r_level && (r_rep_cnt == REP_W'(REPEAT_CYCLES - 1));

        // Counts the held time; starts from zero on the cycle the level goes high.
        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                r_rep_cnt <= '0;
            end else if (!r_level || w_repeat) begin
                r_rep_cnt <= '0;
            end else begin
                r_rep_cnt <= r_rep_cnt + 1'b1;
            end
        end
    end else begin : g_no_repeat
        assign w_repeat = 1'b0;
    end

    assign o_rise = w_edge || w_repeat;
`else
    assign o_rise = w_edge;
`endif

endmodule

// File: rtl/meter_cmd_scheduler.sv
// Serialises debounced button/switch events and the countdown tick into one command per cycle.
// Build macro BUTTON_REPEAT_EN enables hold-to-repeat on the four credit buttons.
module meter_cmd_scheduler
    import meter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_DIV        = 100_000_000,
    parameter int PHASE_DIV       = 200_000_000
`ifdef BUTTON_REPEAT_EN
    , parameter int REPEAT_CYCLES = 50_000_000
`endif
)(
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             btn_u,
    input  logic             btn_l,
    input  logic             btn_r,
    input  logic             btn_d,
    input  logic             sw_10,
    input  logic             sw_205,
    output logic             cmd_valid,
    output logic [1:0]       cmd_op,
    output logic [CMD_W-1:0] cmd_value,
    output logic [1:0]       phase,
    output logic             led
);

    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PHASE_W = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;

    logic               r_rst_meta;
    logic               r_rst_sync;
    logic               w_rst_n;
    logic [NUM_SRC-1:0] w_raw;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] r_pend;
    logic [NUM_SRC-1:0] w_clear;
    logic               r_tick_pend;
    logic               w_clear_tick;
    logic [TICK_W-1:0]  r_tick_cnt;
    logic               w_tick_wrap;
    logic [PHASE_W-1:0] r_phase_cnt;
    logic [1:0]         r_phase;
    cmd_op_e            w_op;
    logic [CMD_W-1:0]   w_value;
    logic               w_load;
    logic               r_cmd_valid;
    cmd_op_e            r_cmd_op;
    logic [CMD_W-1:0]   r_cmd_value;
    logic               r_led;

    // Reset asserts asynchronously everywhere but is released on a clock edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_rst_n = r_rst_sync;

    assign w_raw[SRC_SW10]  = sw_10;
    assign w_raw[SRC_SW205] = sw_205;
    assign w_raw[SRC_BTN_U] = btn_u;
    assign w_raw[SRC_BTN_L] = btn_l;
    assign w_raw[SRC_BTN_R] = btn_r;
    assign w_raw[SRC_BTN_D] = btn_d;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_inputs
        meter_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BUTTON_REPEAT_EN
            , .REPEAT_CYCLES(REPEAT_CYCLES),
            .CAN_REPEAT(g >= SRC_BTN_U)
`endif
        ) u_debounce (
            .CLK(CLK),
            .RESET_N(w_rst_n),
            .i_raw(w_raw[g]),
            .o_rise(w_rise[g])
        );
    end

    assign w_tick_wrap = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

    // Fixed-priority pick: presets, then the countdown tick, then credit buttons.
    always_comb begin
        w_op         = OP_NOP;
        w_value      = '0;
        w_clear      = '0;
        w_clear_tick = 1'b0;
        if (r_pend[SRC_SW10]) begin
            w_op              = OP_LOAD;
            w_value           = srcAmount(SRC_SW10);
            w_clear[SRC_SW10] = 1'b1;
        end else if (r_pend[SRC_SW205]) begin
            w_op               = OP_LOAD;
            w_value            = srcAmount(SRC_SW205);
            w_clear[SRC_SW205] = 1'b1;
        end else if (r_tick_pend) begin
            w_op         = OP_DEC;
            w_value      = AMT_DEC;
            w_clear_tick = 1'b1;
        end else if (r_pend[SRC_BTN_U]) begin
            w_op               = OP_ADD;
            w_value            = srcAmount(SRC_BTN_U);
            w_clear[SRC_BTN_U] = 1'b1;
        end else if (r_pend[SRC_BTN_L]) begin
            w_op               = OP_ADD;
            w_value            = srcAmount(SRC_BTN_L);
            w_clear[SRC_BTN_L] = 1'b1;
        end else if (r_pend[SRC_BTN_R]) begin
            w_op               = OP_ADD;
            w_value            = srcAmount(SRC_BTN_R);
            w_clear[SRC_BTN_R] = 1'b1;
        end else if (r_pend[SRC_BTN_D]) begin
            w_op               = OP_ADD;
            w_value            = srcAmount(SRC_BTN_D);
            w_clear[SRC_BTN_D] = 1'b1;
        end
    end

    assign w_load = (w_op == OP_LOAD);

    // A LOAD restarts the countdown so the next DEC is a full tick away.
    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pend      <= '0;
            r_tick_pend <= 1'b0;
            r_tick_cnt  <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clear) | w_rise;
            if (w_load) begin
                r_tick_cnt  <= '0;
                r_tick_pend <= 1'b0;
            end else begin
                r_tick_cnt  <= w_tick_wrap ? '0 : r_tick_cnt + 1'b1;
                r_tick_pend <= (r_tick_pend & ~w_clear_tick) | w_tick_wrap;
            end
        end
    end

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_phase_cnt <= '0;
            r_phase     <= 2'd0;
        end else if (r_phase_cnt == PHASE_W'(PHASE_DIV - 1)) begin
            r_phase_cnt <= '0;
            r_phase     <= r_phase + 2'd1;
        end else begin
            r_phase_cnt <= r_phase_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= OP_NOP;
            r_cmd_value <= '0;
            r_led       <= 1'b0;
        end else begin
            r_cmd_valid <= (w_op != OP_NOP);
            r_cmd_op    <= w_op;
            r_cmd_value <= w_value;
            r_led       <= r_led || w_load;
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_op    = r_cmd_op;
    assign cmd_value = r_cmd_value;
    assign phase     = r_phase;
    assign led       = r_led;

endmodule

// File: doc/meter_cmd_scheduler.md
Name: meter_cmd_scheduler

Overview:
Front-end controller for the parking-meter time counter. It debounces and edge-detects the four credit buttons and two preset switches, and generates the 1-second countdown tick and the 2-second display-phase sequence. It serialises all of these into a single one-command-per-cycle stream to the counter datapath, so simultaneous events are never lost or merged. It sits between the board I/O and the counter/display block.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable samples required before a debounced input changes
TICK_DIV, 100_000_000, CLK cycles per countdown tick (1 s at 100 MHz)
PHASE_DIV, 200_000_000, CLK cycles per display-phase advance (2 s)
REPEAT_CYCLES, 50_000_000, hold-repeat interval (used only with the optional feature)

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
btn_u, btn_l, btn_r, btn_d  in  1 each  raw credit buttons (async, bouncy)
sw_10, sw_205  in  1 each  raw preset switches
cmd_valid  out  1  one-cycle command strobe
cmd_op  out  2  0=NOP, 1=LOAD, 2=ADD, 3=DEC
cmd_value  out  14  LOAD value or ADD amount; 1 for DEC
phase  out  2  display flash phase, 0→1→2→3→0
led  out  1  set on the first LOAD, cleared only by reset

Behaviour:
- Reset (async assert, sync release): all synchronisers, debounced states, pending bits, prescalers and outputs are 0. cmd_op is NOP, phase is 0, led is 0.
- Each raw input passes through a 2-flop synchroniser, then a per-input debounce counter. The debounced level toggles only after DEBOUNCE_CYCLES consecutive samples that differ from it. The counter clears on any sample equal to the current level.
- A debounced rising edge sets that source's pending bit. Falling edges do nothing. A new edge on an already-pending source is absorbed, not counted twice.
- Tick prescaler counts 0..TICK_DIV-1. At wrap it sets tick_pending.
- Phase prescaler counts 0..PHASE_DIV-1. At wrap, phase increments mod 4. phase is free-running and is never affected by commands.
- Arbiter issues at most one command per cycle. The command is registered, so cmd_* appears 1 cycle after the pending bit is visible. Fixed priority:
  1. sw_10: LOAD 10
  2. sw_205: LOAD 205
  3. tick: DEC 1
  4. btn_u: ADD 10
  5. btn_l: ADD 180
  6. btn_r: ADD 200
  7. btn_d: ADD 550
- The served pending bit clears in the same cycle it is issued. Unserved bits persist, so N simultaneous sources are issued over N consecutive cycles in priority order.
- Issuing a LOAD also clears tick_pending and restarts the tick prescaler at 0, so the first DEC after a LOAD comes exactly TICK_DIV cycles later.
- If both LOADs are pending, LOAD 10 issues first and LOAD 205 issues in the next cycle; the later value wins at the counter.
- led sets in the cycle the first LOAD strobe is driven.
- Saturation at 9999 and underflow protection are the counter's responsibility. This block never suppresses an ADD or DEC based on count.
- When idle: cmd_valid=0, cmd_op=NOP, cmd_value=0.
- Reset asserted mid-sequence discards all pending bits immediately.

Optional Feature:
BUTTON_REPEAT_EN
- Defined: while a credit button remains debounced-high, its pending bit re-sets every REPEAT_CYCLES after the initial edge. Each button has its own repeat counter, cleared on release. Preset switches never repeat.
- Undefined: one ADD per press. The repeat counters and the REPEAT_CYCLES logic are not synthesised.

Decomposition:
- Package meter_pkg holds:
  - cmd_op enum (NOP/LOAD/ADD/DEC)
  - source index constants
  - amount constants: 10, 180, 200, 550, 205, 9999
  - CMD_W=14
- One natural sub-module: meter_debounce (synchroniser + debounce counter + rising-edge pulse), instantiated six times.

Test Plan:
All tests use DEBOUNCE_CYCLES=4, TICK_DIV=16, PHASE_DIV=32.
1. btn_u held 10 cycles with 2-cycle bounce glitches at its start → exactly one ADD 10, issued 2(sync)+4(debounce)+1 cycles after the last glitch edge.
2. btn_l and btn_d rise in the same cycle → ADD 180, then ADD 550 on the next cycle; no other commands.
3. sw_205 pulse → LOAD 205, led=1. No DEC for 16 cycles after the LOAD, then DEC 1 every 16 cycles.
4. Tick wrap in the same cycle as a btn_r edge becomes pending → DEC 1, then ADD 200 next cycle. Tick cadence is unchanged.
5. sw_10 and sw_205 together → LOAD 10, then LOAD 205. Assert RESET_N low mid-pattern with btn_u pending → outputs zero immediately and no ADD after release.
6. With BUTTON_REPEAT_EN and REPEAT_CYCLES=8: btn_r held 30 cycles after debounce → ADD 200 at debounce+1 and then every 8 cycles (4 commands total). Without the macro → 1 command.
